// File: rtl/fetch_prefetch_unit_if.sv
// Bus between the fetch front end, instruction memory and the decode stage.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instruction, if_id_pc,
    input  imem_ready, imem_rvalid, imem_rdata, stall, flush, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_instruction, if_id_pc,
    output imem_ready, imem_rvalid, imem_rdata, stall, flush, branch_target
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues in-order fetches, buffers returned words in a
// prefetch FIFO and loads IF/ID, squashing in-flight responses on a branch redirect.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = DEPTH[CntW:0];

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;
  logic [31:0]     if_id_pc_q, if_id_pc_d;

  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];

  logic [CntW:0] credit_used;
  logic          req, issue, resp, dropping, push, pop;

  // Credit covers both buffered words and words still in flight, so a push never overflows.
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
  assign req         = !rst && !bus.flush && (credit_used < DepthC);
  assign issue       = req && bus.imem_ready;
  assign resp        = bus.imem_rvalid && (outstanding_q != '0);
  assign dropping    = resp && (drop_cnt_q != '0);
  assign push        = resp && !dropping && !bus.flush;
  assign pop         = !bus.flush && !bus.stall && (fifo_cnt_q != '0);

  assign bus.imem_req          = req;
  assign bus.imem_addr         = fetch_pc_q;
  assign bus.if_id_valid       = if_id_valid_q;
  assign bus.if_id_instruction = if_id_instr_q;
  assign bus.if_id_pc          = if_id_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CntW'(issue) - CntW'(resp);
    drop_cnt_d    = drop_cnt_q;
    fifo_cnt_d    = fifo_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if (bus.flush) begin
      // Everything still in flight after this cycle belongs to the squashed path.
      fetch_pc_d    = bus.branch_target;
      resp_pc_d     = bus.branch_target;
      drop_cnt_d    = outstanding_q - CntW'(resp);
      fifo_cnt_d    = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      if_id_valid_d = 1'b0;
      if_id_instr_d = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (dropping) drop_cnt_d = drop_cnt_q - CntW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
      if (!bus.stall) begin
        if (pop) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = fifo_instr_q[rd_ptr_q];
          if_id_pc_d    = fifo_pc_q[rd_ptr_q];
        end else begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ({1'b0, fifo_cnt_q} < DepthC));
  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (outstanding_q != '0));
endmodule
